// File: rtl/fix16_to_float12.sv
// fix16_to_float12: converts a signed 16-bit fixed-point value (FRAC_BITS
// fractional bits) into a 12-bit float {sign, exp[4:0] bias 15, man[5:0]}
// through a three-stage valid/ready pipeline: magnitude, normalize, round/pack.
module fix16_to_float12 #(
  parameter int FRAC_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [11:0] data_o,
  output logic        valid_o,
  input  logic        ready_i
);

  // The whole pipeline moves together: it stalls only when a result sits
  // at the output and downstream refuses it.
  logic adv;

  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;

  // Stage 1 registers: sign and absolute value of the input.
  logic        s1_valid;
  logic        s1_sign;
  logic [15:0] s1_mag;

  // Stage 2 registers: left-justified magnitude and unbiased-plus-bias exponent.
  logic        s2_valid;
  logic        s2_sign;
  logic        s2_zero;
  logic [15:0] s2_norm;
  logic [4:0]  s2_exp;

  // Combinational helpers feeding the stage registers.
  logic [15:0] mag_next;
  logic [3:0]  lead_pos;
  logic [15:0] norm_next;
  logic [4:0]  exp_next;
  logic [6:0]  man_sum;
  logic [4:0]  pack_exp;
  logic [5:0]  pack_man;
  logic [11:0] pack_word;

  // The leading one and the bits below the round bit do not affect the
  // result (rounding looks only at the single bit after the mantissa).
  logic unused_norm_bits;

  assign unused_norm_bits = ^{s2_norm[15], s2_norm[7:0]};

  // Two's-complement absolute value; 16'h8000 maps to itself, which reads
  // correctly as the unsigned magnitude 32768.
  always_comb begin
    mag_next = data_i;
    if (data_i[15]) begin
      mag_next = ~data_i + 16'd1;
    end
  end

  // Capture sign and magnitude of each accepted input.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (adv) begin
      s1_valid <= valid_i & ready_o;
      s1_sign  <= data_i[15];
      s1_mag   <= mag_next;
    end
  end

  // Priority search for the most significant set bit; later iterations
  // overwrite earlier ones so the highest set bit wins.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (s1_mag[i]) begin
        lead_pos = i[3:0];
      end
    end
  end

  // Shift the leading one up to bit 15 and derive the biased exponent;
  // legal FRAC_BITS keeps the exponent inside 1..30, so 5 bits suffice.
  always_comb begin
    norm_next = s1_mag << (4'd15 - lead_pos);
    exp_next  = 5'd15 + {1'b0, lead_pos} - 5'(FRAC_BITS);
  end

  // Register the normalized magnitude, exponent and zero flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_norm  <= '0;
      s2_exp   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= (s1_mag == 16'd0);
      s2_norm  <= norm_next;
      s2_exp   <= exp_next;
    end
  end

  // Round half away from zero on the magnitude, bump the exponent when the
  // mantissa overflows, and force an all-zero word for a zero input.
  always_comb begin
    man_sum  = {1'b0, s2_norm[14:9]} + {6'd0, s2_norm[8]};
    pack_exp = s2_exp;
    pack_man = man_sum[5:0];
    if (man_sum[6]) begin
      pack_exp = s2_exp + 5'd1;
      pack_man = '0;
    end
    pack_word = {s2_sign, pack_exp, pack_man};
    if (s2_zero) begin
      pack_word = 12'h000;
    end
  end

  // Output register; data only changes when a new valid result arrives so
  // it stays put while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (adv) begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        data_o <= pack_word;
      end
    end
  end

endmodule

// File: tb/tb_fix16_to_float12.sv
// tb_fix16_to_float12: scenario tasks for the fixed-to-float12 pipeline,
// with a behavioural conversion model and a scoreboard for random traffic.
module tb_fix16_to_float12;

  localparam int FRAC_BITS = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] data_o;
  logic        valid_o;
  logic        ready_i;

  int errors = 0;
  int checks = 0;

  fix16_to_float12 #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Reference conversion from the numeric definition: value = d / 2^FRAC_BITS,
  // exponent from the power of two of the magnitude, 6 fraction bits rounded
  // half-up on the magnitude using one extra bit.
  function automatic logic [11:0] ref_float(input logic [15:0] d);
    int v, mag, p, e, q, r;
    logic sgn;
    v   = int'($signed(d));
    sgn = (v < 0);
    mag = sgn ? -v : v;
    if (mag == 0) return 12'h000;
    p = 0;
    while ((1 << (p + 1)) <= mag) p++;
    e = 15 + p - FRAC_BITS;
    q = (mag * 128) / (1 << p);
    r = (q + 1) / 2;
    if (r == 128) begin
      e = e + 1;
      r = 64;
    end
    return {sgn, 5'(e), 6'(r - 64)};
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b0;
    data_i  = 16'h1234;
    repeat (3) @(posedge clk_i);
    #2;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid_o got=%b want=0", valid_o);
    end
    checks++;
    if (data_o !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_data_o got=%h want=000", data_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready_o got=%b want=1", ready_o);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    next_cycle();
  endtask

  task automatic test_stream();
    logic [15:0] ins [4];
    logic [11:0] exps [4];
    logic        exp_v;
    ins  = '{16'h0100, 16'hFF00, 16'h0000, 16'h8000};
    exps = '{12'h3C0, 12'hBC0, 12'h000, 12'hD80};
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      valid_i = (c < 4);
      data_i  = (c < 4) ? ins[c] : 16'h0000;
      @(negedge clk_i);
      exp_v = (c >= 3 && c <= 6);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("[TB] FAIL stream_valid cycle=%0d got=%b want=%b", c, valid_o, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (data_o !== exps[c-3]) begin
          errors++;
          $display("[TB] FAIL stream_data cycle=%0d got=%h want=%h", c, data_o, exps[c-3]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_rounding();
    logic [15:0] ins [5];
    logic [11:0] exps [5];
    logic        exp_v;
    ins  = '{16'h01FF, 16'h0102, 16'h0001, 16'hFFFF, 16'h7FFF};
    exps = '{12'h400, 12'h3C1, 12'h1C0, 12'h9C0, 12'h580};
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      valid_i = (c < 5);
      data_i  = (c < 5) ? ins[c] : 16'h0000;
      @(negedge clk_i);
      exp_v = (c >= 3 && c <= 7);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("[TB] FAIL round_valid cycle=%0d got=%b want=%b", c, valid_o, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (data_o !== exps[c-3]) begin
          errors++;
          $display("[TB] FAIL round_data in=%h got=%h want=%h", ins[c-3], data_o, exps[c-3]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] items [4];
    int idx, acc, outn;
    for (int i = 0; i < 4; i++) items[i] = 16'($urandom);
    ready_i = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      valid_i = 1'b1;
      data_i  = items[idx];
      @(negedge clk_i);
      checks++;
      if (ready_o !== (c < 3)) begin
        errors++;
        $display("[TB] FAIL bp_ready cycle=%0d got=%b want=%b", c, ready_o, (c < 3));
      end
      if (ready_o) acc++;
      next_cycle();
      idx = acc;
    end
    checks++;
    if (acc != 3) begin
      errors++;
      $display("[TB] FAIL bp_accepted got=%0d want=3", acc);
    end
    for (int h = 0; h < 4; h++) begin
      valid_i = 1'b1;
      data_i  = items[idx];
      @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall valid_o=%b ready_o=%b want valid_o=1 ready_o=0", valid_o, ready_o);
      end
      checks++;
      if (data_o !== ref_float(items[0])) begin
        errors++;
        $display("[TB] FAIL bp_hold got=%h want=%h", data_o, ref_float(items[0]));
      end
      next_cycle();
    end
    ready_i = 1'b1;
    outn = 0;
    for (int c = 0; c < 16; c++) begin
      valid_i = (idx < 4);
      data_i  = (idx < 4) ? items[idx] : 16'h0000;
      @(negedge clk_i);
      if (valid_o) begin
        checks++;
        if (outn >= 4) begin
          errors++;
          $display("[TB] FAIL bp_extra_output got=%h want=none", data_o);
        end else if (data_o !== ref_float(items[outn])) begin
          errors++;
          $display("[TB] FAIL bp_drain item=%0d got=%h want=%h", outn, data_o, ref_float(items[outn]));
        end
        outn++;
      end
      if (valid_i && ready_o) idx++;
      next_cycle();
    end
    checks++;
    if (outn != 4 || idx != 4) begin
      errors++;
      $display("[TB] FAIL bp_count outputs=%0d accepted=%0d want 4 and 4", outn, idx);
    end
  endtask

  task automatic test_reset_mid_flight();
    logic [15:0] items [2];
    logic [15:0] fresh;
    logic        exp_v;
    for (int i = 0; i < 2; i++) items[i] = 16'($urandom);
    ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      valid_i = 1'b1;
      data_i  = items[c];
      next_cycle();
    end
    valid_i = 1'b0;
    next_cycle();
    checks++;
    if (valid_o !== 1'b1 || data_o !== ref_float(items[0])) begin
      errors++;
      $display("[TB] FAIL midrst_before valid_o=%b data_o=%h want 1 and %h", valid_o, data_o, ref_float(items[0]));
    end
    #1 rst_n_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 12'h000 || ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_async valid_o=%b data_o=%h ready_o=%b want 0 000 1", valid_o, data_o, ready_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_stale cycle=%0d got=%b want=0", c, valid_o);
      end
      next_cycle();
    end
    fresh = 16'($urandom);
    for (int c = 0; c < 6; c++) begin
      valid_i = (c == 0);
      data_i  = fresh;
      @(negedge clk_i);
      exp_v = (c == 3);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("[TB] FAIL first_latency cycle=%0d got=%b want=%b", c, valid_o, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (data_o !== ref_float(fresh)) begin
          errors++;
          $display("[TB] FAIL first_data got=%h want=%h", data_o, ref_float(fresh));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [11:0] sb [$];
    logic [11:0] expd;
    int pick;
    for (int n = 0; n < 3000; n++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 9);
      case (pick)
        0:       data_i = 16'h0000;
        1:       data_i = 16'h8000;
        2:       data_i = 16'h7FFF;
        3:       data_i = 16'hFFFF;
        default: data_i = 16'($urandom);
      endcase
      @(negedge clk_i);
      checks++;
      if (ready_o !== (~valid_o | ready_i)) begin
        errors++;
        $display("[TB] FAIL rand_ready got=%b valid_o=%b ready_i=%b", ready_o, valid_o, ready_i);
      end
      if (valid_o && ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_unexpected got=%h want=none", data_o);
        end else begin
          expd = sb.pop_front();
          if (data_o !== expd) begin
            errors++;
            $display("[TB] FAIL rand_data got=%h want=%h", data_o, expd);
          end
        end
      end
      if (valid_i && ready_o) sb.push_back(ref_float(data_i));
      next_cycle();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      if (valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_drain_unexpected got=%h want=none", data_o);
        end else begin
          expd = sb.pop_front();
          if (data_o !== expd) begin
            errors++;
            $display("[TB] FAIL rand_drain_data got=%h want=%h", data_o, expd);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_leftover got=%0d want=0", sb.size());
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting fix16_to_float12 bench, FRAC_BITS=%0d", FRAC_BITS);
    test_reset();
    test_stream();
    test_rounding();
    test_backpressure();
    test_reset_mid_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so a stuck pipeline cannot hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fix16_to_float12.md
FIX16_TO_FLOAT12 -- requirements
Module: fix16_to_float12

Interface
REQ-001 SHALL: clock and reset are fixed as one clock, with asynchronous, active-low reset.
REQ-002 SHALL: parameter FRAC_BITS, default 8, number of fractional bits of the signed fixed-point input (legal range 0..14).
REQ-003 SHALL: port clk_i  input  1  rising-edge clock.
REQ-004 SHALL: port rst_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL: port data_i  input  16  two's-complement fixed-point value, interpreted as data_i / 2^FRAC_BITS.
REQ-006 SHALL: port valid_i  input  1  data_i valid.
REQ-007 SHALL: port ready_o  output  1  block accepts data_i this cycle.
REQ-008 SHALL: port data_o  output  12  float12 result {sign[11], exp[10:6] bias 15, man[5:0] hidden-one}; zero is encoded as 12'h000.
REQ-009 SHALL: port valid_o  output  1  data_o valid.
REQ-010 SHALL: port ready_i  input  1  downstream accepts data_o.

Function
REQ-011 SHALL: internal advance enable is adv = ~valid_o | ready_i; ready_o = adv (combinational).
REQ-012 SHALL: an input transfer occurs when valid_i & ready_o; an output transfer occurs when valid_o & ready_i.
REQ-013 SHALL: a 3-stage pipeline (S1 magnitude, S2 normalize, S3 round/pack) shifts one stage per cycle when adv=1 and holds all stage registers and valid bits when adv=0.
REQ-014 SHALL: latency is 3 cycles from input transfer to valid_o when ready_i is held 1; throughput is one result per cycle.
REQ-015 SHALL: each stage carries a valid bit; the S1 valid bit loads valid_i & ready_o; bubbles propagate as valid=0.
REQ-016 SHALL: S1 registers sign = data_i[15] and mag = |data_i| as 16-bit unsigned; 16'h8000 yields mag 16'h8000.
REQ-017 SHALL: S2 finds the leading-one position p (0..15) of mag, left-shifts mag so the leading one lands at bit 15 (norm), and sets exp = 15 + p - FRAC_BITS; mag=0 sets a zero flag.
REQ-018 SHALL: S3 takes man = norm[14:9] and round bit r = norm[8], rounding to nearest with ties away from zero (man + r).
REQ-019 SHALL: on a mantissa carry-out, S3 sets man = 0 and exp = exp + 1.
REQ-020 SHALL: a zero flag produces data_o = 12'h000 with sign forced to 0.
REQ-021 SHALL: exp never leaves 1..30 for legal FRAC_BITS, so no saturation or underflow logic is required; FRAC_BITS outside 0..14 is illegal.
REQ-022 SHALL: data_o and valid_o are registered outputs; data_o is stable while valid_o=1 and ready_i=0.
REQ-023 SHALL: when valid_o=0, data_o holds its last value (don't-care for checking).

Reset
REQ-024 SHALL: while rst_n_i=0, all stage valid bits, valid_o and data_o are cleared to 0 asynchronously; ready_o therefore reads 1.
REQ-025 SHALL: reset asserted mid-operation discards all in-flight data; no output transfer follows for items accepted before reset.
REQ-026 SHALL: the first input transfer after reset deassertion produces valid_o exactly 3 cycles later (ready_i=1).

Verification
REQ-027 SHALL: with FRAC_BITS=8 and ready_i=1, a stream of 0x0100, 0xFF00, 0x0000, 0x8000 on consecutive cycles -> data_o 0x3C0, 0xBC0, 0x000, 0xD80 on 4 consecutive cycles, starting 3 cycles after the first transfer.
REQ-028 SHALL: input 0x01FF -> 0x400 (exercises carry into exponent).
REQ-029 SHALL: input 0x0102 -> 0x3C1 (exact tie rounds away from zero).
REQ-030 SHALL: with ready_i=0 and 4 inputs offered, 3 are accepted; then valid_o=1, ready_o=0, and data_o is held; releasing ready_i drains all results in order with none lost or duplicated.
REQ-031 SHALL: rst_n_i pulsed low with 2 items in flight -> valid_o=0 immediately, and no stale outputs appear after release.
REQ-032 SHALL: a random stream with random valid_i and ready_i, checked against a scoreboard model of REQ-016..REQ-020, shows order preserved and bit-exact results.
